// File: rtl/vec_magnitude_iter_pkg.sv
// Shared definitions for the iterative vector-magnitude block:
// FSM state encoding, operating-mode constants and derived-width helpers.
package vec_mag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_MAG   = 1'b0;
    localparam logic MODE_SUMSQ = 1'b1;

    function automatic int sum_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int out_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/vec_magnitude_iter_isqrt_serial.sv
// Restoring bit-serial integer square root: one root bit per enabled cycle, MSB first.
// done pulses for one enabled cycle once root/rem hold the final result.
module isqrt_serial #(
    parameter int RAD_W  = 17,
    parameter int ROOT_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic [RAD_W-1:0]  radicand,
    output logic              done,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem
);
    localparam int PAD_W = 2 * ROOT_W;
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam int ACC_W = ROOT_W + 3;

    logic [PAD_W-1:0]  rad_reg;
    logic [ROOT_W-1:0] root_reg;
    logic [ROOT_W:0]   rem_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    trial;
    logic              ge;
    logic [ROOT_W:0]   rem_next;
    logic [ROOT_W-1:0] root_next;
    logic              unused_trial_hi;

    // rem never exceeds 2*root, so the low ROOT_W+1 bits of the kept value are exact
    always_comb begin
        acc             = {rem_reg, rad_reg[PAD_W-1 -: 2]};
        trial           = {1'b0, acc} - {2'b00, root_reg, 2'b01};
        ge              = ~trial[ACC_W];
        rem_next        = ge ? trial[ROOT_W:0] : acc[ROOT_W:0];
        root_next       = {root_reg[ROOT_W-2:0], ge};
        unused_trial_hi = ^trial[ACC_W-1:ROOT_W+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_reg  <= '0;
            root_reg <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (ena) begin
            done_reg <= 1'b0;
            if (start) begin
                rad_reg  <= PAD_W'(radicand);
                root_reg <= '0;
                rem_reg  <= '0;
                cnt_reg  <= CNT_W'(ROOT_W - 1);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rad_reg  <= rad_reg << 2;
                rem_reg  <= rem_next;
                root_reg <= root_next;
                cnt_reg  <= cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign root = root_reg;
    assign rem  = rem_reg;

endmodule

// File: rtl/vec_magnitude_iter.sv
// Iterative vector magnitude: floor(sqrt(x^2 + y^2)) or x^2 + y^2, one operation
// in flight at a time, valid/ready handshake on input and output.
module vec_magnitude_iter
    import vec_mag_pkg::*;
#(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0,
    localparam int SUM_W = sum_w(W),
    localparam int OUT_W = out_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_data,
    output logic             out_exact
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SQ   = SQ;
    localparam logic [1:0] ST_ROOT = ROOT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_reg, state_next;
    logic [W-1:0]     x_reg, y_reg;
    logic             mode_reg;
    logic [SUM_W-1:0] sum_reg;
    logic             out_valid_reg;
    logic [SUM_W-1:0] out_data_reg;
    logic             out_exact_reg;

    logic [W-1:0]     x_abs, y_abs;
    logic [SUM_W-1:0] x_ext, y_ext, sum_calc;
    logic             sqrt_start, sqrt_done;
    logic [OUT_W-1:0] sqrt_root;
    logic [OUT_W:0]   sqrt_rem;

    // two's-complement negate of -2^(W-1) yields 2^(W-1), valid as a W-bit unsigned value
    always_comb begin
        x_abs    = (SIGNED && in_x[W-1]) ? (~in_x + 1'b1) : in_x;
        y_abs    = (SIGNED && in_y[W-1]) ? (~in_y + 1'b1) : in_y;
        x_ext    = SUM_W'(x_reg);
        y_ext    = SUM_W'(y_reg);
        sum_calc = x_ext * x_ext + y_ext * y_ext;
    end

    assign sqrt_start = (state_reg == ST_SQ) && (mode_reg == MODE_MAG);

    isqrt_serial #(
        .RAD_W  (SUM_W),
        .ROOT_W (OUT_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .start    (sqrt_start),
        .radicand (sum_calc),
        .done     (sqrt_done),
        .root     (sqrt_root),
        .rem      (sqrt_rem)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_SQ;
            ST_SQ:   state_next = (mode_reg == MODE_SUMSQ) ? ST_DONE : ST_ROOT;
            ST_ROOT: if (sqrt_done) state_next = ST_DONE;
            ST_DONE: if (out_valid_reg && out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Sum mode enters DONE unpublished and publishes sum_reg on its first DONE cycle;
    // magnitude mode publishes the root on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            mode_reg      <= 1'b0;
            sum_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_exact_reg <= 1'b0;
        end else if (ena) begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg    <= x_abs;
                        y_reg    <= y_abs;
                        mode_reg <= in_mode;
                    end
                end
                ST_SQ: begin
                    sum_reg <= sum_calc;
                end
                ST_ROOT: begin
                    if (sqrt_done) begin
                        out_data_reg  <= SUM_W'(sqrt_root);
                        out_exact_reg <= (sqrt_rem == '0);
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_reg) begin
                        out_data_reg  <= sum_reg;
                        out_exact_reg <= 1'b1;
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_exact = out_exact_reg;

endmodule

// File: tb/tb_vec_magnitude_iter.sv
// Directed bench for vec_magnitude_iter: an unsigned and a signed W=8 instance
// share clock, reset, enable and operand buses.
module tb_vec_magnitude_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        in_valid_u = 1'b0, in_valid_s = 1'b0;
    logic        in_ready_u, in_ready_s;
    logic [7:0]  in_x = '0, in_y = '0;
    logic        in_mode = 1'b0;
    logic        out_valid_u, out_valid_s;
    logic        out_ready = 1'b0;
    logic [16:0] out_data_u, out_data_s;
    logic        out_exact_u, out_exact_s;

    logic        sel = 1'b0;
    logic        cur_valid, cur_ready, cur_exact;
    logic [16:0] cur_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_magnitude_iter #(.W(8), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid_u), .in_ready(in_ready_u),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_exact(out_exact_u)
    );

    vec_magnitude_iter #(.W(8), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_exact(out_exact_s)
    );

    assign cur_valid = sel ? out_valid_s : out_valid_u;
    assign cur_ready = sel ? in_ready_s  : in_ready_u;
    assign cur_exact = sel ? out_exact_s : out_exact_u;
    assign cur_data  = sel ? out_data_s  : out_data_u;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        in_valid_u = v & ~sel;
        in_valid_s = v & sel;
    endtask

    // One operation: accept, optional enable stall at edge stall_at, wait for result,
    // optional backpressure hold / frozen-DONE probe, then handshake.
    task automatic do_op(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                         input logic mode, input int exp_data, input logic exp_exact,
                         input int exp_lat, input int stall_at, input int hold, input bit freeze);
        int lat;
        sel = s;
        #0;
        check({tag, "_in_ready"}, 32'(cur_ready), 32'd1);
        in_x = x; in_y = y; in_mode = mode;
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        in_x = 8'hA5; in_y = 8'h5A; in_mode = ~mode;
        check({tag, "_busy"}, 32'(cur_ready), 32'd0);
        lat = 0;
        while (!cur_valid && lat < 40) begin
            if (lat == stall_at) ena = 1'b0;
            if (lat == stall_at + 3) ena = 1'b1;
            tick();
            lat++;
        end
        ena = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(cur_data), 32'(exp_data));
        check({tag, "_exact"}, 32'(cur_exact), 32'(exp_exact));
        if (hold > 0) begin
            set_valid(1'b1);
            in_x = 8'd1; in_y = 8'd1;
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, "_hold_valid"}, 32'(cur_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(cur_data), 32'(exp_data));
                check({tag, "_hold_in_ready"}, 32'(cur_ready), 32'd0);
            end
            set_valid(1'b0);
        end
        if (freeze) begin
            ena = 1'b0;
            out_ready = 1'b1;
            tick();
            check({tag, "_frozen_valid"}, 32'(cur_valid), 32'd1);
            ena = 1'b1;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(cur_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(cur_ready), 32'd1);
        $display("txn %s: x=%0d y=%0d mode=%0d -> data=%0d exact=%0d latency=%0d",
                 tag, x, y, mode, exp_data, exp_exact, lat);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        sel = 1'b0;
        #0;
        check("rst_in_ready_u", 32'(in_ready_u), 32'd1);
        check("rst_out_valid_u", 32'(out_valid_u), 32'd0);
        check("rst_out_data_u", 32'(out_data_u), 32'd0);
        check("rst_out_exact_u", 32'(out_exact_u), 32'd0);
        check("rst_in_ready_s", 32'(in_ready_s), 32'd1);
        check("rst_out_valid_s", 32'(out_valid_s), 32'd0);
        rst = 1'b0;
        tick();

        do_op("mag_3_4",     1'b0, 8'd3,   8'd4,   1'b0, 5,      1'b1, 11, -10, 0, 1'b0);
        do_op("mag_255_255", 1'b0, 8'd255, 8'd255, 1'b0, 360,    1'b0, 11, -10, 0, 1'b0);
        do_op("mag_0_0",     1'b0, 8'd0,   8'd0,   1'b0, 0,      1'b1, 11, -10, 0, 1'b0);
        do_op("sum_12_5",    1'b0, 8'd12,  8'd5,   1'b1, 169,    1'b1, 2,  -10, 0, 1'b0);
        do_op("sum_255_255", 1'b0, 8'd255, 8'd255, 1'b1, 130050, 1'b1, 2,  -10, 0, 1'b0);
        do_op("backpressure", 1'b0, 8'd6,  8'd8,   1'b0, 10,     1'b1, 11, -10, 5, 1'b0);
        repeat (2) tick();
        check("bp_no_accept", 32'(out_valid_u), 32'd0);
        do_op("ena_stall",   1'b0, 8'd8,   8'd15,  1'b0, 17,     1'b1, 14, 5,   0, 1'b1);

        // Abort an operation mid-root with reset, then check nothing stale survives.
        sel = 1'b0;
        in_x = 8'd100; in_y = 8'd100; in_mode = 1'b0;
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid_u), 32'd0);
        check("midrst_in_ready", 32'(in_ready_u), 32'd1);
        check("midrst_out_data", 32'(out_data_u), 32'd0);
        $display("txn midrst: x=100 y=100 aborted by reset");
        do_op("after_rst_5_12", 1'b0, 8'd5, 8'd12, 1'b0, 13, 1'b1, 11, -10, 0, 1'b0);

        do_op("s_mag_m128_m128", 1'b1, 8'h80, 8'h80, 1'b0, 181, 1'b0, 11, -10, 0, 1'b0);
        do_op("s_mag_m6_8",      1'b1, 8'hFA, 8'd8,  1'b0, 10,  1'b1, 11, -10, 0, 1'b0);
        do_op("s_sum_m12_5",     1'b1, 8'hF4, 8'd5,  1'b1, 169, 1'b1, 2,  -10, 0, 1'b0);
        do_op("s_mag_127_m128",  1'b1, 8'd127, 8'h80, 1'b0, 180, 1'b0, 11, -10, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
